// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings and defaults for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int unsigned DEF_DEPTH_WORDS = 16384;
   localparam int unsigned DEF_IDX_WIDTH   = 14;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant: on a tie the port that did not win last time is chosen.
module rr_arbiter2
   import data_mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic grant_valid,
   output logic grant
);

   logic last_grant;

   always_comb begin
      grant_valid = req0 | req1;
      grant       = PORT0;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else if (req1) begin
         grant = PORT1;
      end
   end

   // Reset to PORT1 so that port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= PORT1;
      end else if (advance && grant_valid) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port synchronous data memory between two requesters via IDLE/ACCESS/DONE.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int unsigned IDX_WIDTH   = DEF_IDX_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_ready,
   output logic                  p0_err,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ready,
   output logic                  p1_err,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [IDX_WIDTH-1:0]  mem_idx,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                state;
   logic                  grant_valid;
   logic                  grant;
   logic                  advance;
   logic                  lat_port;
   logic                  lat_we;
   logic                  lat_err;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic                  sel_we;
   logic                  sel_err;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ADDR_WIDTH-1:0] sel_word;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  done_read;
   logic [DATA_WIDTH-1:0] read_word;

   assign advance = (state == ST_IDLE);

   rr_arbiter2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req0        (p0_req),
      .req1        (p1_req),
      .advance     (advance),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Request mux and address check on the full-width address, before any truncation.
   always_comb begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
      if (grant == PORT1) begin
         sel_we    = p1_we;
         sel_addr  = p1_addr;
         sel_wdata = p1_wdata;
      end
      sel_word = sel_addr >> 2;
      sel_err  = (sel_addr[1:0] != 2'b00) || (sel_word >= ADDR_WIDTH'(DEPTH_WORDS));
   end

   // Memory data only arrives in DONE, so it is forwarded there and captured for holding.
   assign done_read = (state == ST_DONE) && !lat_we;
   assign read_word = lat_err ? '0 : mem_rdata;
   assign p0_rdata  = (done_read && lat_port == PORT0) ? read_word : rdata0_q;
   assign p1_rdata  = (done_read && lat_port == PORT1) ? read_word : rdata1_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_idx   <= '0;
         mem_wdata <= '0;
         p0_ready  <= 1'b0;
         p1_ready  <= 1'b0;
         p0_err    <= 1'b0;
         p1_err    <= 1'b0;
         lat_port  <= PORT0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         p0_ready <= 1'b0;
         p1_ready <= 1'b0;
         p0_err   <= 1'b0;
         p1_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  lat_port  <= grant;
                  lat_we    <= sel_we;
                  lat_err   <= sel_err;
                  mem_en    <= !sel_err;
                  mem_we    <= sel_we && !sel_err;
                  mem_idx   <= sel_addr[IDX_WIDTH+1:2];
                  mem_wdata <= sel_wdata;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               p0_ready <= (lat_port == PORT0);
               p1_ready <= (lat_port == PORT1);
               p0_err   <= (lat_port == PORT0) && lat_err;
               p1_err   <= (lat_port == PORT1) && lat_err;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (done_read) begin
                  if (lat_port == PORT0) begin
                     rdata0_q <= read_word;
                  end else begin
                     rdata1_q <= read_word;
                  end
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: vector table, multi-cycle corner sequences and randomized traffic vs a transaction model.
module tb_data_mem_arbiter;

   localparam int unsigned DEPTH = 16384;

   logic        clk;
   logic        reset;
   logic        p0_req, p0_we, p0_ready, p0_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_ready, p1_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic        mem_en, mem_we;
   logic [13:0] mem_idx;
   logic [31:0] mem_wdata, mem_rdata;

   data_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ready(p0_ready), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ready(p1_ready), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory: read data appears the cycle after mem_en.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_idx] <= mem_wdata;
         else        mem_rdata    <= mem[mem_idx];
      end
   end

   int tests = 0;
   int fails = 0;

   // Transaction-level model state.
   bit          model_last;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] exp_rd [2];

   typedef struct {
      bit          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [13];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void model_apply(input int port, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic err, output logic [31:0] rd);
      err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
      if (!err && we) ref_mem[addr / 4] = wdata;
      if (!we) exp_rd[port] = err ? 32'h0 : (ref_mem.exists(addr / 4) ? ref_mem[addr / 4] : 32'h0);
      rd = exp_rd[port];
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_mem_en"},    64'(mem_en),    64'd0);
      check({tag, "_mem_we"},    64'(mem_we),    64'd0);
      check({tag, "_mem_idx"},   64'(mem_idx),   64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, "_ready"},     64'({p0_ready, p1_ready}), 64'd0);
      check({tag, "_err"},       64'({p0_err, p1_err}),     64'd0);
      check({tag, "_p0_rdata"},  64'(p0_rdata),  64'd0);
      check({tag, "_p1_rdata"},  64'(p1_rdata),  64'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      p0_req = 1'b0;
      p1_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      model_last = 1'b1;
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
   endtask

   // Drive one or both requests from IDLE and check every completion against the model.
   task automatic serve(input bit rq0, input bit rq1, input logic we0, input logic we1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        output logic err0, output logic err1,
                        output logic [31:0] rd0, output logic [31:0] rd1);
      bit          pend [2];
      logic        w [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      int          next_port, rp, n_done, en_seen, en_exp;
      logic        x_err, o_err;
      logic [31:0] x_rd, o_rd;
      w[0] = we0; w[1] = we1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      err0 = 1'b0; err1 = 1'b0; rd0 = 32'h0; rd1 = 32'h0;
      @(negedge clk);
      p0_req = rq0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
      p1_req = rq1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
      pend[0] = rq0; pend[1] = rq1;
      next_port = (rq0 && rq1) ? (model_last ? 0 : 1) : (rq0 ? 0 : 1);
      n_done = 0; en_seen = 0; en_exp = 0;
      for (int cyc = 1; cyc <= 20 && (pend[0] || pend[1]); cyc++) begin
         @(negedge clk);
         if (mem_en) begin
            en_seen++;
            check("access_idx", 64'(mem_idx), 64'(14'(a[next_port] >> 2)));
            check("access_we", 64'(mem_we), 64'(w[next_port]));
            if (w[next_port]) check("access_wdata", 64'(mem_wdata), 64'(d[next_port]));
         end
         if (p0_ready && p1_ready) check("single_ready", 64'd1, 64'd0);
         if (p0_ready || p1_ready) begin
            rp = p1_ready ? 1 : 0;
            check("grant_order", 64'(rp), 64'(next_port));
            check("latency", 64'(cyc), n_done == 0 ? 64'd2 : 64'd5);
            model_apply(rp, w[rp], a[rp], d[rp], x_err, x_rd);
            if (!x_err) en_exp++;
            o_err = rp ? p1_err : p0_err;
            o_rd  = rp ? p1_rdata : p0_rdata;
            check("err", 64'(o_err), 64'(x_err));
            check("rdata", 64'(o_rd), 64'(x_rd));
            check("other_err", 64'(rp ? p0_err : p1_err), 64'd0);
            if (rp == 0) begin p0_req = 1'b0; err0 = o_err; rd0 = o_rd; end
            else         begin p1_req = 1'b0; err1 = o_err; rd1 = o_rd; end
            pend[rp] = 1'b0;
            model_last = rp[0];
            n_done++;
            next_port = 1 - rp;
         end
      end
      check("serve_timeout", 64'({pend[0], pend[1]}), 64'd0);
      check("mem_en_count", 64'(en_seen), 64'(en_exp));
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] base;
      int r;
      r = $urandom_range(0, 11);
      base = (r < 8) ? 32'(r) * 4 : 32'(DEPTH - 12 + r) * 4;
      case ($urandom_range(0, 9))
         7: return base | 32'($urandom_range(1, 3));
         8: return base + 32'h0001_0000;
         9: return 32'hFFFF_FFFC;
         default: return base;
      endcase
   endfunction

   logic        e0, e1;
   logic [31:0] r0, r1, addr_a, addr_b;
   int          seen, rc, rp;

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_8000, 32'h0000_0009, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 1'b0, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'h0000_0009};
      vecs[2]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0000_0000};
      vecs[3]  = '{1'b1, 1'b1, 32'h0001_0000, 32'h0000_DEAD, 1'b1, 32'h0000_0000};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_1234};
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_8002, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_FFFC, 32'h0000_A5A5, 1'b0, 32'h0000_0000};
      vecs[7]  = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0000_0000, 1'b0, 32'h0000_A5A5};
      vecs[8]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 1'b1, 32'h8000_0000, 32'h0000_5555, 1'b1, 32'h0000_1234};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_1234};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_8001, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'h0000_0009};

      reset = 1'b0;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
      apply_reset();

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].port == 1'b0) begin
            serve(1'b1, 1'b0, vecs[i].we, 1'b0, vecs[i].addr, 32'h0, vecs[i].wdata, 32'h0, e0, e1, r0, r1);
         end else begin
            serve(1'b0, 1'b1, 1'b0, vecs[i].we, 32'h0, vecs[i].addr, 32'h0, vecs[i].wdata, e1, e0, r1, r0);
         end
         check($sformatf("vec%0d_err", i), 64'(e0), 64'(vecs[i].exp_err));
         check($sformatf("vec%0d_rdata", i), 64'(r0), 64'(vecs[i].exp_rdata));
      end

      // Both reads held from reset: grants alternate p0,p1,p0,p1 three cycles apart.
      apply_reset();
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0000;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_FFFC;
      seen = 0;
      for (int c = 1; c <= 16 && seen < 4; c++) begin
         @(negedge clk);
         if (p0_ready || p1_ready) begin
            rp = p1_ready ? 1 : 0;
            check("tie_order", 64'(rp), 64'(seen % 2));
            check("tie_spacing", 64'(c), 64'(2 + 3 * seen));
            check("tie_rdata", 64'(rp ? p1_rdata : p0_rdata), 64'(rp ? ref_mem[32'h3FFF] : ref_mem[32'h0]));
            seen++;
         end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      check("tie_count", 64'(seen), 64'd4);
      model_last = 1'b1;
      exp_rd[0] = ref_mem[32'h0];
      exp_rd[1] = ref_mem[32'h3FFF];

      // Request dropped during ACCESS still completes exactly once.
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0000_0040; p0_wdata = 32'h0000_0077;
      @(negedge clk);
      check("drop_access", 64'({mem_en, mem_we}), 64'd3);
      p0_req = 1'b0;
      rc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (p0_ready) rc++;
         if (p1_ready) rc += 10;
      end
      check("drop_ready_count", 64'(rc), 64'd1);
      model_apply(0, 1'b1, 32'h0000_0040, 32'h0000_0077, e0, r0);
      model_last = 1'b0;
      serve(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0, e0, e1, r0, r1);

      // Reset asserted during the ACCESS cycle of a write.
      @(negedge clk);
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0100; p1_wdata = 32'h0000_0BAD;
      @(negedge clk);
      check("rst_access", 64'({mem_en, mem_we}), 64'd3);
      reset = 1'b0;
      p1_req = 1'b0;
      @(negedge clk);
      check_zero("rst_mid");
      reset = 1'b1;
      rc = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (p0_ready || p1_ready || mem_en) rc++;
      end
      check("rst_quiet", 64'(rc), 64'd0);
      model_last = 1'b1;
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      serve(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_FFFC, 32'h0, 32'h0, e0, e1, r0, r1);

      // Randomized traffic over a preloaded pool of words, with errored addresses mixed in.
      for (int k = 0; k < 12; k++) begin
         addr_a = (k < 8) ? 32'(k) * 4 : 32'(DEPTH - 12 + k) * 4;
         serve(1'b1, 1'b0, 1'b1, 1'b0, addr_a, 32'h0, $urandom, 32'h0, e0, e1, r0, r1);
      end
      for (int n = 0; n < 60; n++) begin
         int  sel;
         sel = $urandom_range(1, 3);
         addr_a = rand_addr();
         addr_b = rand_addr();
         serve(sel[0], sel[1], 1'($urandom), 1'($urandom), addr_a, addr_b,
               $urandom, $urandom, e0, e1, r0, r1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Arbitrates one word-aligned, single-port synchronous data memory between two requesters: port 0 (processor load/store path) and port 1 (program loader / debug reader).
- Sequences every access through a 3-state FSM with a req/ready handshake.
- Rejects misaligned or out-of-range addresses with an error pulse, and never asserts the memory enable for them.
- Sits between the processor datapath and the data memory array.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 32, width of byte addresses from the requesters.
- DEPTH_WORDS, 16384, memory depth in words.
- IDX_WIDTH, 14, word-index width (log2 DEPTH_WORDS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ready.
- p0_we  in  1  port 0 write enable.
- p0_addr  in  ADDR_WIDTH  port 0 byte address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_ready  out  1  one-cycle completion pulse, port 0.
- p0_err  out  1  one-cycle error pulse, port 0 (coincides with p0_ready).
- p0_rdata  out  DATA_WIDTH  port 0 read data; valid with p0_ready, held until next port 0 completion.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ready, p1_err, p1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_idx  out  IDX_WIDTH  word index (byte address >> 2).
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values (reset low at a clock edge): state IDLE; mem_en, mem_we, p0_ready, p1_ready, p0_err, p1_err all 0; mem_idx, mem_wdata, p0_rdata, p1_rdata all 0; last_grant = 1, so port 0 wins the first tie.
- FSM state IDLE:
  - No req: stay IDLE.
  - Single req: grant that port.
  - Both req: grant the port not equal to last_grant (round-robin).
  - On grant: latch we, addr, wdata; compute err = (addr[1:0] != 0) or ((addr >> 2) >= DEPTH_WORDS); set last_grant to the granted port; go to ACCESS.
- FSM state ACCESS (one cycle):
  - mem_en = !err; mem_we = latched we && !err; mem_idx and mem_wdata driven from the latch.
  - Go to DONE.
- FSM state DONE (one cycle):
  - Granted port's ready = 1 and its err = latched err.
  - For a read without error, the port's rdata register loads mem_rdata; for an error read it loads 0; a write leaves rdata unchanged.
  - Go to IDLE.
- Latency: ready asserts exactly 2 cycles after the IDLE cycle in which req was sampled. Maximum throughput is one access per 3 cycles.
- The non-granted port waits with req held, and is guaranteed the next grant (no starvation). Worst-case wait is 3 cycles.
- Once latched, a transaction completes even if req drops mid-flight; the ready pulse still occurs.
- A requester re-asserting req in the cycle after ready is sampled in IDLE normally.
- mem_en and mem_we are high only in ACCESS, and never for errored requests. Memory is therefore not modified by out-of-range writes.
- Reset mid-transaction: return to IDLE on that edge, no ready/err pulse, no memory write issued after the reset edge.
- Address arithmetic: mem_idx = addr[IDX_WIDTH+1:2]. The range check uses the full ADDR_WIDTH address; upper bits are not truncated before comparison.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Port identifiers: PORT0=1'b0, PORT1=1'b1.
  - Default DEPTH_WORDS and IDX_WIDTH constants.
- One natural sub-module: rr_arbiter2 (two-requester round-robin grant logic with last_grant register). The FSM and datapath latches stay in the top module.

Test Plan:
- Port 0 write: p0_addr=32'h8000, p0_wdata=32'h9, p0_we=1 → mem_en=mem_we=1, mem_idx=14'h2000 in ACCESS; p0_ready one cycle later; memory word 0x2000 = 32'h9. Then read the same address → p0_rdata=32'h9 with p0_ready, 2 cycles after sampling.
- Simultaneous req from reset, both reads: grant order is p0, p1, p0, p1 over 4 transactions with both req held; each ready pulse spaced 3 cycles apart.
- Out-of-range and misaligned:
  - p1 write to 32'h10000 → p1_ready=1 and p1_err=1, mem_en never asserted, memory unchanged.
  - p0 read of 32'h8002 → p0_err=1, p0_rdata=0.
- req dropped in the ACCESS cycle → transaction still completes; ready pulses once; FSM returns to IDLE.
- Reset low during ACCESS of a write → no ready pulse; all outputs 0 next cycle; last_grant=1; following tie goes to port 0.
